// File: rtl/branch_predict_unit_if.sv
// Decode/execute-side signal bundle for the branch/return predictor.
// master: decode + execute stages; slave: branch_predict_unit.
interface branch_predict_unit_if #(
    parameter int unsigned BP_ADDR_BITS = 12,
    parameter int unsigned RAS_DEPTH    = 8
);
    localparam int unsigned RAS_CNT_BITS = $clog2(RAS_DEPTH) + 1;

    logic                     D_stall_i;
    logic                     D_flush_i;
    logic                     D_valid_i;
    logic [31:0]              D_PC_i;
    logic                     D_isJAL_i;
    logic                     D_isJALR_i;
    logic                     D_isBranch_i;
    logic [4:0]               D_rdId_i;
    logic [4:0]               D_rs1Id_i;
    logic [31:0]              D_Jimm_i;
    logic [31:0]              D_Bimm_i;
    logic                     D_predictPC_o;
    logic [31:0]              D_PCprediction_o;
    logic                     D_predictBranch_o;
    logic [BP_ADDR_BITS-1:0]  D_bhtIndex_o;

    logic                     E_stall_i;
    logic                     E_isBranch_i;
    logic                     E_takeBranch_i;
    logic [BP_ADDR_BITS-1:0]  E_bhtIndex_i;
    logic                     E_predictBranch_i;

    logic                     busy_o;
    logic [RAS_CNT_BITS-1:0]  ras_count_o;
    logic [31:0]              stat_branches_o;
    logic [31:0]              stat_mispred_o;

    modport master (
        output D_stall_i, D_flush_i, D_valid_i, D_PC_i, D_isJAL_i, D_isJALR_i,
               D_isBranch_i, D_rdId_i, D_rs1Id_i, D_Jimm_i, D_Bimm_i,
               E_stall_i, E_isBranch_i, E_takeBranch_i, E_bhtIndex_i, E_predictBranch_i,
        input  D_predictPC_o, D_PCprediction_o, D_predictBranch_o, D_bhtIndex_o,
               busy_o, ras_count_o, stat_branches_o, stat_mispred_o
    );

    modport slave (
        input  D_stall_i, D_flush_i, D_valid_i, D_PC_i, D_isJAL_i, D_isJALR_i,
               D_isBranch_i, D_rdId_i, D_rs1Id_i, D_Jimm_i, D_Bimm_i,
               E_stall_i, E_isBranch_i, E_takeBranch_i, E_bhtIndex_i, E_predictBranch_i,
        output D_predictPC_o, D_PCprediction_o, D_predictBranch_o, D_bhtIndex_o,
               busy_o, ras_count_o, stat_branches_o, stat_mispred_o
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Decode-stage gshare BHT + circular return-address stack predictor.
// Optional feature macro: BP_STATS_EN builds the resolved/mispredicted branch counters.
module branch_predict_unit #(
    parameter int unsigned BP_ADDR_BITS = 12,
    parameter int unsigned BH_BITS      = 9,
    parameter int unsigned CTR_BITS     = 2,
    parameter int unsigned RAS_DEPTH    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    branch_predict_unit_if.slave bp
);
    localparam int unsigned BHT_SIZE     = 1 << BP_ADDR_BITS;
    localparam int unsigned HIST_SHIFT   = BP_ADDR_BITS - BH_BITS;
    localparam int unsigned RAS_PTR_BITS = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CNT_BITS = RAS_PTR_BITS + 1;

    localparam logic [CTR_BITS-1:0]     CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0]     CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0]     CTR_MIN     = '0;
    localparam logic [BP_ADDR_BITS-1:0] BHT_LAST    = BP_ADDR_BITS'(BHT_SIZE - 1);
    localparam logic [RAS_CNT_BITS-1:0] RAS_FULL    = RAS_CNT_BITS'(RAS_DEPTH);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } bpState_t;

    bpState_t state;
    bpState_t nextState;
    logic     sweeping;
    logic     isReady;

    logic [BP_ADDR_BITS-1:0] sweepIdx;
    logic [CTR_BITS-1:0]     bht [BHT_SIZE];
    logic [BH_BITS-1:0]      hist;

    logic [BP_ADDR_BITS-1:0] histAligned;
    logic [BP_ADDR_BITS-1:0] dIdx;
    logic [CTR_BITS-1:0]     dCtr;
    logic                    predictBranch;

    logic                    trainEn;
    logic [CTR_BITS-1:0]     trainOld;
    logic [CTR_BITS-1:0]     trainNew;

    logic [31:0]             ras [RAS_DEPTH];
    logic [RAS_PTR_BITS-1:0] rasPtr;
    logic [RAS_PTR_BITS-1:0] rasTopPtr;
    logic [RAS_CNT_BITS-1:0] rasCount;
    logic                    rasNonEmpty;
    logic                    rasEn;
    logic                    isCall;
    logic                    isRet;
    logic                    rasPush;
    logic                    rasPop;
    logic                    rasReplace;
    logic [31:0]             linkAddr;
    logic [31:0]             seqTarget;

    function automatic logic isLink(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // ---------------- init-sweep FSM ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= INIT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            INIT:    if (sweepIdx == BHT_LAST) nextState = READY;
            READY:   nextState = READY;
            default: nextState = INIT;
        endcase
    end

    always_comb begin
        sweeping = 1'b0;
        isReady  = 1'b0;
        case (state)
            INIT:    sweeping = 1'b1;
            READY:   isReady  = 1'b1;
            default: sweeping = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sweepIdx <= '0;
        end else if (sweeping) begin
            sweepIdx <= sweepIdx + BP_ADDR_BITS'(1);
        end
    end

    // ---------------- BHT lookup / training ----------------
    assign histAligned   = BP_ADDR_BITS'(hist) << HIST_SHIFT;
    assign dIdx          = bp.D_PC_i[BP_ADDR_BITS+1:2] ^ histAligned;
    assign dCtr          = bht[dIdx];
    assign predictBranch = isReady & dCtr[CTR_BITS-1];

    assign trainEn  = isReady & ~bp.E_stall_i & bp.E_isBranch_i;
    assign trainOld = bht[bp.E_bhtIndex_i];

    always_comb begin
        trainNew = trainOld;
        if (bp.E_takeBranch_i) begin
            if (trainOld != CTR_MAX) trainNew = trainOld + CTR_BITS'(1);
        end else begin
            if (trainOld != CTR_MIN) trainNew = trainOld - CTR_BITS'(1);
        end
    end

    // The sweep overwrites every entry, so the table itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (sweeping) begin
            bht[sweepIdx] <= CTR_WEAK_NT;
        end else if (trainEn) begin
            bht[bp.E_bhtIndex_i] <= trainNew;
        end
    end

    // Newest outcome enters at the MSB.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hist <= '0;
        end else if (trainEn) begin
            hist <= BH_BITS'({bp.E_takeBranch_i, hist} >> 1);
        end
    end

    // ---------------- return-address stack ----------------
    assign isCall      = (bp.D_isJAL_i | bp.D_isJALR_i) & isLink(bp.D_rdId_i);
    assign isRet       = bp.D_isJALR_i & isLink(bp.D_rs1Id_i)
                         & ~(isLink(bp.D_rdId_i) & (bp.D_rdId_i == bp.D_rs1Id_i));
    assign rasEn       = bp.D_valid_i & ~bp.D_stall_i & ~bp.D_flush_i;
    assign rasNonEmpty = (rasCount != '0);
    assign rasTopPtr   = rasPtr - RAS_PTR_BITS'(1);
    assign linkAddr    = bp.D_PC_i + 32'd4;

    // Coroutine on an empty stack degenerates to a plain push.
    assign rasReplace = rasEn & isCall & isRet & rasNonEmpty;
    assign rasPush    = rasEn & isCall & ~(isRet & rasNonEmpty);
    assign rasPop     = rasEn & isRet & ~isCall & rasNonEmpty;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rasPtr   <= '0;
            rasCount <= '0;
        end else if (rasPush) begin
            rasPtr   <= rasPtr + RAS_PTR_BITS'(1);
            rasCount <= (rasCount == RAS_FULL) ? rasCount : rasCount + RAS_CNT_BITS'(1);
        end else if (rasPop) begin
            rasPtr   <= rasTopPtr;
            rasCount <= rasCount - RAS_CNT_BITS'(1);
        end
    end

    // A push into a full stack lands on the oldest slot, since ptr wraps onto it.
    always_ff @(posedge clk_i) begin
        if (rasPush) begin
            ras[rasPtr] <= linkAddr;
        end else if (rasReplace) begin
            ras[rasTopPtr] <= linkAddr;
        end
    end

    // ---------------- decode-side outputs ----------------
    assign seqTarget = bp.D_PC_i + (bp.D_isJAL_i ? bp.D_Jimm_i : bp.D_Bimm_i);

    assign bp.D_predictBranch_o = predictBranch;
    assign bp.D_bhtIndex_o      = dIdx;
    assign bp.D_predictPC_o     = bp.D_valid_i & (bp.D_isJAL_i
                                                | (bp.D_isJALR_i & rasNonEmpty)
                                                | (bp.D_isBranch_i & predictBranch));
    assign bp.D_PCprediction_o  = bp.D_isJALR_i ? ras[rasTopPtr] : seqTarget;
    assign bp.busy_o            = sweeping;
    assign bp.ras_count_o       = rasCount;

`ifdef BP_STATS_EN
    logic [31:0] statBranches;
    logic [31:0] statMispred;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            statBranches <= '0;
            statMispred  <= '0;
        end else if (trainEn) begin
            statBranches <= statBranches + 32'd1;
            if (bp.E_predictBranch_i != bp.E_takeBranch_i) begin
                statMispred <= statMispred + 32'd1;
            end
        end
    end

    assign bp.stat_branches_o = statBranches;
    assign bp.stat_mispred_o  = statMispred;
`else
    logic unusedStatsIn;

    assign unusedStatsIn      = bp.E_predictBranch_i;
    assign bp.stat_branches_o = '0;
    assign bp.stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit (BP_ADDR_BITS=4, BH_BITS=2, CTR_BITS=2, RAS_DEPTH=4).
module tb_branch_predict_unit;
    localparam int S_BUSY = 0, S_PRED = 1, S_PPC = 2, S_TGT = 3;
    localparam int S_CNT  = 4, S_SBR  = 5, S_SMIS = 6, S_IDX = 7;

    typedef struct {
        string       name;
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t scb[$];

    logic [1:0] tbCtr;
    logic [1:0] tbHist;
    int         tbBr;
    int         tbMis;

    branch_predict_unit_if #(.BP_ADDR_BITS(4), .RAS_DEPTH(4)) bpIf ();

    branch_predict_unit #(
        .BP_ADDR_BITS(4), .BH_BITS(2), .CTR_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bp     (bpIf)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pushExp(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n; e.cyc = cyc; e.sel = s; e.val = v;
        scb.push_back(e);
    endtask

    function automatic logic [31:0] statExp(input int v);
`ifdef BP_STATS_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v * 0);
`endif
    endfunction

    function automatic logic [31:0] pcFor(input int idx, input logic [1:0] h);
        return 32'h1000 | (32'((idx ^ (int'(h) << 2)) & 15) << 2);
    endfunction

    task automatic clearIn();
        bpIf.D_stall_i = 0; bpIf.D_flush_i = 0; bpIf.D_valid_i = 0;
        bpIf.D_PC_i = '0; bpIf.D_isJAL_i = 0; bpIf.D_isJALR_i = 0; bpIf.D_isBranch_i = 0;
        bpIf.D_rdId_i = '0; bpIf.D_rs1Id_i = '0; bpIf.D_Jimm_i = '0; bpIf.D_Bimm_i = '0;
        bpIf.E_stall_i = 0; bpIf.E_isBranch_i = 0; bpIf.E_takeBranch_i = 0;
        bpIf.E_bhtIndex_i = '0; bpIf.E_predictBranch_i = 0;
    endtask

    task automatic lookBranch(input logic [31:0] pc);
        bpIf.D_valid_i = 1; bpIf.D_isBranch_i = 1; bpIf.D_PC_i = pc; bpIf.D_Bimm_i = 32'h20;
    endtask

    task automatic decodeJ(input logic [31:0] pc, input logic jal, input logic [4:0] rd,
                           input logic [4:0] rs1);
        bpIf.D_valid_i = 1; bpIf.D_PC_i = pc; bpIf.D_isJAL_i = jal; bpIf.D_isJALR_i = ~jal;
        bpIf.D_rdId_i = rd; bpIf.D_rs1Id_i = rs1; bpIf.D_Jimm_i = 32'h40;
    endtask

    // Monitor: compare every expectation due in the current cycle, away from the edge.
    exp_t        mE;
    logic [31:0] mAct;
    always @(negedge clk_i) begin
        while (scb.size() > 0 && scb[0].cyc <= cyc) begin
            mE = scb.pop_front();
            case (mE.sel)
                S_BUSY:  mAct = 32'(bpIf.busy_o);
                S_PRED:  mAct = 32'(bpIf.D_predictBranch_o);
                S_PPC:   mAct = 32'(bpIf.D_predictPC_o);
                S_TGT:   mAct = bpIf.D_PCprediction_o;
                S_CNT:   mAct = 32'(bpIf.ras_count_o);
                S_SBR:   mAct = bpIf.stat_branches_o;
                S_SMIS:  mAct = bpIf.stat_mispred_o;
                S_IDX:   mAct = 32'(bpIf.D_bhtIndex_o);
                default: mAct = '1;
            endcase
            checks++;
            if (mE.cyc != cyc) begin
                errors++;
                $display("FAIL %s: stale expectation from cycle %0d seen at cycle %0d",
                         mE.name, mE.cyc, cyc);
            end else if (mAct !== mE.val) begin
                errors++;
                $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                         mE.name, cyc, mAct, mE.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic takes [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    logic [31:0] rets [6] = '{32'h504, 32'h404, 32'h304, 32'h204, 32'h0, 32'h0};
    logic [31:0] pc;

    initial begin
        clearIn();
        tbCtr = 2'b01; tbHist = 2'b00; tbBr = 0; tbMis = 0;

        // Power-up sweep: busy for exactly 16 cycles, no BHT prediction meanwhile.
        step();
        reset_i = 0;
        for (int c = 0; c <= 16; c++) begin
            clearIn();
            pushExp("sweepBusy", S_BUSY, 32'(c < 16));
            if (c == 0) begin
                lookBranch(32'h1014);
                pushExp("initPred", S_PRED, 32'd0);
                pushExp("initRedirect", S_PPC, 32'd0);
                pushExp("resetRasCount", S_CNT, 32'd0);
                pushExp("resetStatBr", S_SBR, 32'd0);
                pushExp("resetStatMis", S_SMIS, 32'd0);
            end
            step();
        end

        // Training at index 5; lookup in the same cycle sees the pre-write counter.
        for (int i = 0; i < 9; i++) begin
            clearIn();
            pc = pcFor(5, tbHist);
            lookBranch(pc);
            bpIf.E_isBranch_i = 1; bpIf.E_takeBranch_i = takes[i];
            bpIf.E_bhtIndex_i = 4'd5; bpIf.E_predictBranch_i = tbCtr[1];
            pushExp("trainIdx", S_IDX, 32'd5);
            pushExp("trainPred", S_PRED, 32'(tbCtr[1]));
            pushExp("trainRedirect", S_PPC, 32'(tbCtr[1]));
            pushExp("branchTarget", S_TGT, pc + 32'h20);
            if (tbCtr[1] != takes[i]) tbMis++;
            tbBr++;
            if (takes[i] && tbCtr != 2'b11) tbCtr = tbCtr + 2'd1;
            else if (!takes[i] && tbCtr != 2'b00) tbCtr = tbCtr - 2'd1;
            tbHist = {takes[i], tbHist[1]};
            step();
        end

        // Stalled execute: counter, history and stats must hold.
        clearIn();
        lookBranch(pcFor(5, tbHist));
        bpIf.E_stall_i = 1; bpIf.E_isBranch_i = 1; bpIf.E_takeBranch_i = 0;
        bpIf.E_bhtIndex_i = 4'd5;
        pushExp("postTrainPred", S_PRED, 32'(tbCtr[1]));
        pushExp("statBr", S_SBR, statExp(tbBr));
        pushExp("statMis", S_SMIS, statExp(tbMis));
        step();
        clearIn();
        lookBranch(pcFor(5, tbHist));
        pushExp("eStallIdx", S_IDX, 32'd5);
        pushExp("eStallPred", S_PRED, 32'(tbCtr[1]));
        pushExp("eStallStatBr", S_SBR, statExp(tbBr));
        step();

        // Five calls into a 4-deep stack, then six returns.
        for (int i = 1; i <= 5; i++) begin
            clearIn();
            decodeJ(32'(i * 256), 1'b1, 5'd1, 5'd0);
            pushExp("callRedirect", S_PPC, 32'd1);
            pushExp("callTarget", S_TGT, 32'(i * 256) + 32'h40);
            pushExp("callCount", S_CNT, 32'((i - 1 > 4) ? 4 : i - 1));
            step();
        end
        for (int i = 0; i < 6; i++) begin
            clearIn();
            decodeJ(32'h600, 1'b0, 5'd0, 5'd1);
            pushExp("retCount", S_CNT, 32'((4 - i < 0) ? 0 : 4 - i));
            pushExp("retRedirect", S_PPC, 32'(i < 4));
            if (i < 4) pushExp("retTarget", S_TGT, rets[i]);
            step();
        end

        // Coroutine replaces the top; rd==rs1 link is a plain push.
        clearIn(); decodeJ(32'h100, 1'b1, 5'd1, 5'd0);
        pushExp("coCallCount", S_CNT, 32'd0); step();
        clearIn(); decodeJ(32'h80, 1'b0, 5'd1, 5'd5);
        pushExp("coTarget", S_TGT, 32'h104); pushExp("coRedirect", S_PPC, 32'd1);
        pushExp("coCount", S_CNT, 32'd1); step();
        clearIn(); decodeJ(32'h200, 1'b0, 5'd1, 5'd1);
        pushExp("coNewTop", S_TGT, 32'h84); pushExp("coCountKept", S_CNT, 32'd1); step();
        clearIn(); decodeJ(32'h300, 1'b0, 5'd0, 5'd1);
        pushExp("sameRdRs1Push", S_CNT, 32'd2); pushExp("sameRdRs1Top", S_TGT, 32'h204); step();
        clearIn(); decodeJ(32'h300, 1'b0, 5'd0, 5'd1);
        pushExp("coPopTarget", S_TGT, 32'h84); step();
        clearIn();
        pushExp("coEmpty", S_CNT, 32'd0);

        // Stall, flush, nop and non-link JAL leave the stack alone.
        decodeJ(32'h700, 1'b1, 5'd1, 5'd0); bpIf.D_stall_i = 1;
        pushExp("stallRedirect", S_PPC, 32'd1); step();
        pushExp("dStallCount", S_CNT, 32'd0);
        bpIf.D_stall_i = 0; bpIf.D_flush_i = 1; step();
        pushExp("dFlushCount", S_CNT, 32'd0);
        bpIf.D_flush_i = 0; bpIf.D_valid_i = 0;
        pushExp("nopRedirect", S_PPC, 32'd0); step();
        pushExp("nopCount", S_CNT, 32'd0);
        bpIf.D_valid_i = 1; bpIf.D_rdId_i = 5'd0; step();
        pushExp("noLinkCount", S_CNT, 32'd0);
        clearIn();

        // Reset while READY, then reset again mid-sweep at cycle 7.
        reset_i = 1; step(); reset_i = 0;
        tbHist = 2'b00; tbBr = 0; tbMis = 0; tbCtr = 2'b01;
        for (int c = 0; c <= 7; c++) begin
            clearIn();
            pushExp("midBusy", S_BUSY, 32'd1);
            if (c == 0) begin
                lookBranch(32'h1014);
                pushExp("initGatePred", S_PRED, 32'd0);
                pushExp("initGateIdx", S_IDX, 32'd5);
                pushExp("reset2Count", S_CNT, 32'd0);
                pushExp("reset2StatBr", S_SBR, 32'd0);
            end
            if (c == 1) begin
                decodeJ(32'h900, 1'b1, 5'd1, 5'd0);
                pushExp("initCallCount", S_CNT, 32'd0);
            end
            if (c == 2) pushExp("initRasActive", S_CNT, 32'd1);
            if (c == 7) reset_i = 1;
            step();
        end
        reset_i = 0;
        for (int c = 0; c <= 16; c++) begin
            clearIn();
            pushExp("restartBusy", S_BUSY, 32'(c < 16));
            if (c == 0) pushExp("restartCount", S_CNT, 32'd0);
            if (c == 10 || c == 11) begin
                bpIf.E_isBranch_i = 1; bpIf.E_takeBranch_i = 1; bpIf.E_bhtIndex_i = 4'd0;
            end
            if (c == 16) begin
                lookBranch(32'h1000);
                pushExp("initTrainIgnoredIdx", S_IDX, 32'd0);
                pushExp("initTrainIgnoredPred", S_PRED, 32'd0);
            end
            step();
        end

        // Index 5 freshly swept to weakly not-taken; one taken training flips it.
        clearIn();
        lookBranch(pcFor(5, tbHist));
        bpIf.E_isBranch_i = 1; bpIf.E_takeBranch_i = 1; bpIf.E_bhtIndex_i = 4'd5;
        bpIf.E_predictBranch_i = 0;
        pushExp("sweptPred", S_PRED, 32'd0);
        tbBr++; tbMis++; tbHist = {1'b1, tbHist[1]};
        step();
        clearIn();
        lookBranch(pcFor(5, tbHist));
        pushExp("afterSweepIdx", S_IDX, 32'd5);
        pushExp("afterSweepPred", S_PRED, 32'd1);
        pushExp("finalStatBr", S_SBR, statExp(tbBr));
        pushExp("finalStatMis", S_SMIS, statExp(tbMis));
        step();
        clearIn();
        step();
        step();

        checks++;
        if (scb.size() != 0) begin
            errors++;
            $display("FAIL scoreboardDrain: %0d expectations left, expected 0", scb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
